operand_unpacker_mc: RTL and testbench
======================================

OPERAND_UNPACKER_MC -- requirements
Module: operand_unpacker_mc

Interface
REQ-001 Parameter NCH, default 2: number of independent GCD channels (1..8).
REQ-002 Parameter OPW, default 1279: operand width in bits.
REQ-003 Parameter RESW, default 1284: result width in bits.
REQ-004 Parameter DW, default 64: SRAM-port data width (multiple of 8).
REQ-005 Parameter AW, default 32: SRAM-port address width (byte address).
REQ-006 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-007 CLK  in  1  sole clock; all state changes on rising edge.
REQ-008 RESET  in  1  asynchronous, active-high reset.
REQ-009 SRAM_CEn  in  1  access strobe, active-low.
REQ-010 SRAM_ADDR  in  AW  byte address.
REQ-011 SRAM_WDATA  in  DW  write data.
REQ-012 SRAM_WEn  in  1  0 = write, 1 = read.
REQ-013 SRAM_WBEn  in  DW/8  byte enables, active-low.
REQ-014 SRAM_RDATA  out  DW  registered read data.
REQ-015 START  out  NCH  per-channel one-cycle start pulse to the GCD core.
REQ-016 DONE  in  NCH  per-channel completion level from the GCD core.
REQ-017 ARG_A, ARG_B  out  NCH*OPW each  operand registers; channel c occupies bits [c*OPW +: OPW].
REQ-018 RESULT_A, RESULT_B  in  NCH*RESW each  results; channel c at [c*RESW +: RESW].
REQ-019 IRQ  out  1  level interrupt.

Function
REQ-020 Decode: channel = ADDR[12 +: clog2(NCH)], stride 0x1000; offset = ADDR[11:0], word index = offset[8:3] within each region; bits ADDR[2:0] ignored.
REQ-021 Regions per channel: 0x000 CTRL; 0x100 ARG_A; 0x300 ARG_B (RW); 0x500 RESULT_A; 0x700 RESULT_B (RO); word i of a region holds bits [i*DW +: DW].
REQ-022 CTRL write: bit0=1 requests start; bit1 = irq_en; bit2=1 clears done (W1C). CTRL read: bit0 busy, bit1 irq_en, bit2 done, rest 0.
REQ-023 Writes honour WBEn per byte; operand bits at index >= OPW are discarded.
REQ-024 Read data SHALL appear on SRAM_RDATA the cycle after the CEn=0/WEn=1 cycle and hold until the next read.
REQ-025 Reads of unmapped offsets, word indices beyond region size, or channel index >= NCH SHALL return 0; such writes SHALL be ignored.
REQ-026 Per-channel FSM IDLE -> RUN on start request: START[c] high for exactly the following cycle, done cleared.
REQ-027 RUN -> IDLE on first cycle DONE[c] is sampled high after START (level, sampled from the cycle after START); on that edge RESULT_A/B[c] captured into result registers and done set.
REQ-028 In RUN: start requests and ARG_A/ARG_B writes for that channel SHALL be ignored; result reads return the previous capture.
REQ-029 Capture and done-W1C in the same cycle: done ends set.
REQ-030 IRQ = OR over channels of (done & irq_en), registered, one cycle after done sets.

Reset
REQ-031 On RESET: all FSMs IDLE, START=0, SRAM_RDATA=0, IRQ=0, ARG/result registers, done and irq_en = 0; asserting RESET during RUN SHALL abandon the operation with no START or capture afterwards.

Configuration
REQ-032 Macro OPERAND_UNPACKER_IRQ_EN: defined -> REQ-030 behaviour; undefined -> IRQ tied 0, irq_en not stored, CTRL bit1 reads 0, all other behaviour unchanged.

Structure
REQ-033 Package operand_unpacker_pkg SHALL hold region offsets, CTRL bit positions, FSM state enum and the words-per-width function (ceil(W/DW)).
REQ-034 Sub-module operand_unpacker_chan SHALL hold one channel's FSM, operands and result capture; the top instantiates NCH copies plus decode and read mux.

Verification
REQ-035 Write ARG_A ch0 word0 = 0x1122334455667788, WBEn=0xF0 -> ARG_A[31:0]=0x55667788, bits[63:32]=0.
REQ-036 Write ch1 CTRL=0x1 -> START[1] one cycle, CTRL read = 0x1; DONE[1] high with RESULT_A=5 -> RESULT_A ch1 word0 reads 5, CTRL read = 0x4.
REQ-037 During ch0 RUN, write ARG_B word0 = 0xFFFF -> ARG_B unchanged; second CTRL=0x1 -> no second START.
REQ-038 irq_en=1, completion -> IRQ=1 one cycle after done; CTRL write 0x6 -> IRQ=0 next cycle; macro undefined -> IRQ stays 0.
REQ-039 Read ARG_A word 20 (0x1A0) and channel 3 with NCH=2 -> RDATA=0; RESET during RUN -> START/IRQ 0, CTRL reads 0.

Source files
------------

// File: rtl/operand_unpacker_pkg.sv
// rtl/operand_unpacker_pkg.sv - shared constants, types and helpers for the operand unpacker
// Purpose: holds the register-map offsets, CTRL bit positions, the channel FSM
//   state enum, the region enum, the words-per-width function and the
//   address-decode helpers used by the top and the channel.
// Ports: none (package).
package operand_unpacker_pkg;

  // Region base offsets within one channel's 4 KiB window
  localparam logic [11:0] OFF_CTRL  = 12'h000;
  localparam logic [11:0] OFF_ARG_A = 12'h100;
  localparam logic [11:0] OFF_ARG_B = 12'h300;
  localparam logic [11:0] OFF_RES_A = 12'h500;
  localparam logic [11:0] OFF_RES_B = 12'h700;
  localparam logic [11:0] OFF_END   = 12'h900;

  // CTRL register bit positions
  localparam int CTRL_START_BIT  = 0;  // write: start request, read: busy
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_DONE_BIT   = 2;  // write: 1 clears done, read: done

  // Channel field is sized for the largest supported channel count (8) so
  // that an out-of-range channel is detected instead of aliasing a real one.
  localparam int CHAN_FIELD_LSB = 12;
  localparam int CHAN_FIELD_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } chan_state_e;

  typedef enum logic [2:0] {
    RG_NONE  = 3'd0,
    RG_CTRL  = 3'd1,
    RG_ARG_A = 3'd2,
    RG_ARG_B = 3'd3,
    RG_RES_A = 3'd4,
    RG_RES_B = 3'd5
  } region_e;

  function automatic int words_for(input int w, input int dw);
    return (w + dw - 1) / dw;
  endfunction

  // CTRL is a single word; the rest of 0x000-0x0FF and everything from 0x900 is unmapped
  function automatic region_e region_of(input logic [11:0] off);
    region_e r;
    if (off[11:3] == OFF_CTRL[11:3]) r = RG_CTRL;
    else if (off < OFF_ARG_A)        r = RG_NONE;
    else if (off < OFF_ARG_B)        r = RG_ARG_A;
    else if (off < OFF_RES_A)        r = RG_ARG_B;
    else if (off < OFF_RES_B)        r = RG_RES_A;
    else if (off < OFF_END)          r = RG_RES_B;
    else                             r = RG_NONE;
    return r;
  endfunction

  // All data regions sit on 0x200 boundaries offset by 0x100, so one
  // subtraction yields the in-region word index for any of them.
  function automatic logic [5:0] word_of(input logic [11:0] off);
    return 6'((off - OFF_ARG_A) >> 3);
  endfunction

endpackage

// File: rtl/operand_unpacker_chan.sv
// rtl/operand_unpacker_chan.sv - one GCD channel: FSM, operand registers, result capture
// Purpose: holds one channel's IDLE/START/RUN FSM, the ARG_A/ARG_B operand
//   registers with byte-enabled word writes, result capture on DONE, the
//   done/irq_en status bits and the per-channel word read mux.
// Ports: clk/rst (async active-high); ctrl_wr_i + ctrl_bits_i (CTRL write);
//   arg_wr_i/region_i/widx_i/wdata_i/wbe_n_i (operand write); rdata_o (word
//   selected by region_i/widx_i); start_o/done_i (GCD core handshake);
//   result_a_i/result_b_i; arg_a_o/arg_b_o; irq_req_o (done & irq_en).
// Config: OPERAND_UNPACKER_IRQ_EN defined stores irq_en; otherwise it reads 0.
module operand_unpacker_chan
  import operand_unpacker_pkg::*;
#(
  parameter int OPW  = 1279,
  parameter int RESW = 1284,
  parameter int DW   = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ctrl_wr_i,
  input  logic [2:0]      ctrl_bits_i,
  input  logic            arg_wr_i,
  input  logic [2:0]      region_i,
  input  logic [5:0]      widx_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] wbe_n_i,
  output logic [DW-1:0]   rdata_o,
  output logic            start_o,
  input  logic            done_i,
  input  logic [RESW-1:0] result_a_i,
  input  logic [RESW-1:0] result_b_i,
  output logic [OPW-1:0]  arg_a_o,
  output logic [OPW-1:0]  arg_b_o,
  output logic            irq_req_o
);

  localparam int OPW_WORDS = words_for(OPW, DW);
  localparam int OPW_PAD   = OPW_WORDS * DW;
  localparam int RES_WORDS = words_for(RESW, DW);
  localparam int RES_PAD   = RES_WORDS * DW;

  chan_state_e     state_q, state_d;
  logic [OPW-1:0]  arg_a_q, arg_a_d, arg_b_q, arg_b_d;
  logic [RESW-1:0] res_a_q, res_a_d, res_b_q, res_b_d;
  logic            done_q, done_d;
  logic            irq_en, busy, capture, start_req, done_clr;
  logic [DW-1:0]      byte_mask;
  logic [OPW_PAD-1:0] word_mask, wdata_rep, arg_a_pad, arg_b_pad;
  logic [RES_PAD-1:0] res_a_pad, res_b_pad;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; DONE is only looked at in RUN, i.e. from the cycle after START
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_req) state_d = ST_START;
      ST_START: state_d = ST_RUN;
      ST_RUN:   if (done_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    start_o = (state_q == ST_START);
    busy    = (state_q != ST_IDLE);
    capture = (state_q == ST_RUN) && done_i;
  end

  // Operand merge, result capture and done bookkeeping
  always_comb begin
    start_req = ctrl_wr_i && ctrl_bits_i[CTRL_START_BIT] && !busy;
    done_clr  = ctrl_wr_i && ctrl_bits_i[CTRL_DONE_BIT];
    for (int b = 0; b < DW / 8; b++) byte_mask[b*8 +: 8] = {8{~wbe_n_i[b]}};
    word_mask = '0;
    if (int'(widx_i) < OPW_WORDS) word_mask[int'(widx_i)*DW +: DW] = byte_mask;
    wdata_rep = {OPW_WORDS{wdata_i}};
    arg_a_pad = OPW_PAD'(arg_a_q);
    arg_b_pad = OPW_PAD'(arg_b_q);
    res_a_pad = RES_PAD'(res_a_q);
    res_b_pad = RES_PAD'(res_b_q);
    arg_a_d = arg_a_q;
    arg_b_d = arg_b_q;
    // Truncating back to OPW drops anything written above the operand width
    if (arg_wr_i && !busy) begin
      if (region_i == RG_ARG_A) arg_a_d = OPW'((arg_a_pad & ~word_mask) | (wdata_rep & word_mask));
      if (region_i == RG_ARG_B) arg_b_d = OPW'((arg_b_pad & ~word_mask) | (wdata_rep & word_mask));
    end
    res_a_d = capture ? result_a_i : res_a_q;
    res_b_d = capture ? result_b_i : res_b_q;
    // Capture has priority so a same-cycle W1C cannot lose a completion
    done_d = done_q;
    if (start_req || done_clr) done_d = 1'b0;
    if (capture)               done_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arg_a_q <= '0;
      arg_b_q <= '0;
      res_a_q <= '0;
      res_b_q <= '0;
      done_q  <= 1'b0;
    end else begin
      arg_a_q <= arg_a_d;
      arg_b_q <= arg_b_d;
      res_a_q <= res_a_d;
      res_b_q <= res_b_d;
      done_q  <= done_d;
    end
  end

`ifdef OPERAND_UNPACKER_IRQ_EN
  logic irq_en_q, irq_en_d;
  always_comb begin
    irq_en_d = irq_en_q;
    if (ctrl_wr_i) irq_en_d = ctrl_bits_i[CTRL_IRQ_EN_BIT];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_en_q <= 1'b0;
    else     irq_en_q <= irq_en_d;
  end
  assign irq_en = irq_en_q;
`else
  logic unused_irq_en;
  assign unused_irq_en = ctrl_bits_i[CTRL_IRQ_EN_BIT];
  assign irq_en        = 1'b0;
`endif

  // Word read mux; indices past the end of a region read as zero
  always_comb begin
    rdata_o = '0;
    case (region_i)
      RG_CTRL: begin
        rdata_o[CTRL_START_BIT]  = busy;
        rdata_o[CTRL_IRQ_EN_BIT] = irq_en;
        rdata_o[CTRL_DONE_BIT]   = done_q;
      end
      RG_ARG_A: if (int'(widx_i) < OPW_WORDS) rdata_o = arg_a_pad[int'(widx_i)*DW +: DW];
      RG_ARG_B: if (int'(widx_i) < OPW_WORDS) rdata_o = arg_b_pad[int'(widx_i)*DW +: DW];
      RG_RES_A: if (int'(widx_i) < RES_WORDS) rdata_o = res_a_pad[int'(widx_i)*DW +: DW];
      RG_RES_B: if (int'(widx_i) < RES_WORDS) rdata_o = res_b_pad[int'(widx_i)*DW +: DW];
      default:  rdata_o = '0;
    endcase
  end

  assign arg_a_o   = arg_a_q;
  assign arg_b_o   = arg_b_q;
  assign irq_req_o = done_q & irq_en;

endmodule

// File: rtl/operand_unpacker_mc.sv
// rtl/operand_unpacker_mc.sv - multi-channel SRAM-port register front end for GCD cores
// Purpose: decodes SRAM-style accesses into per-channel CTRL/operand/result
//   regions, instantiates NCH channels, registers read data and the IRQ.
// Ports: CLK, RESET (async active-high); SRAM_CEn/ADDR/WDATA/WEn/WBEn in,
//   SRAM_RDATA out (registered); START out / DONE in per channel;
//   ARG_A/ARG_B out and RESULT_A/RESULT_B in, channel-packed; IRQ out.
// Config: OPERAND_UNPACKER_IRQ_EN defined enables the registered IRQ; otherwise IRQ is 0.
module operand_unpacker_mc
  import operand_unpacker_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int OPW  = 1279,
  parameter int RESW = 1284,
  parameter int DW   = 64,
  parameter int AW   = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                SRAM_CEn,
  input  logic [AW-1:0]       SRAM_ADDR,
  input  logic [DW-1:0]       SRAM_WDATA,
  input  logic                SRAM_WEn,
  input  logic [DW/8-1:0]     SRAM_WBEn,
  output logic [DW-1:0]       SRAM_RDATA,
  output logic [NCH-1:0]      START,
  input  logic [NCH-1:0]      DONE,
  output logic [NCH*OPW-1:0]  ARG_A,
  output logic [NCH*OPW-1:0]  ARG_B,
  input  logic [NCH*RESW-1:0] RESULT_A,
  input  logic [NCH*RESW-1:0] RESULT_B,
  output logic                IRQ
);

  logic [11:0]             offset;
  logic [CHAN_FIELD_W-1:0] chan;
  logic [2:0]              region;
  logic [5:0]              widx;
  logic                    wr_cyc, rd_cyc;
  logic [DW-1:0]           rdata_q, rdata_d, rd_word;
  logic [DW-1:0]           chan_rdata [NCH];
  logic [NCH-1:0]          chan_irq;
  logic                    unused_addr_hi;

  always_comb begin
    offset = SRAM_ADDR[11:0];
    chan   = SRAM_ADDR[CHAN_FIELD_LSB +: CHAN_FIELD_W];
    region = region_of(offset);
    widx   = word_of(offset);
    wr_cyc = !SRAM_CEn && !SRAM_WEn;
    rd_cyc = !SRAM_CEn && SRAM_WEn;
  end

  assign unused_addr_hi = ^SRAM_ADDR[AW-1:CHAN_FIELD_LSB+CHAN_FIELD_W];

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    logic hit;
    assign hit = (chan == CHAN_FIELD_W'(c));
    operand_unpacker_chan #(.OPW(OPW), .RESW(RESW), .DW(DW)) u_chan (
      .clk        (CLK),
      .rst        (RESET),
      .ctrl_wr_i  (wr_cyc && hit && (region == RG_CTRL) && !SRAM_WBEn[0]),
      .ctrl_bits_i(SRAM_WDATA[2:0]),
      .arg_wr_i   (wr_cyc && hit),
      .region_i   (region),
      .widx_i     (widx),
      .wdata_i    (SRAM_WDATA),
      .wbe_n_i    (SRAM_WBEn),
      .rdata_o    (chan_rdata[c]),
      .start_o    (START[c]),
      .done_i     (DONE[c]),
      .result_a_i (RESULT_A[c*RESW +: RESW]),
      .result_b_i (RESULT_B[c*RESW +: RESW]),
      .arg_a_o    (ARG_A[c*OPW +: OPW]),
      .arg_b_o    (ARG_B[c*OPW +: OPW]),
      .irq_req_o  (chan_irq[c])
    );
  end

  // Channel select; a channel field >= NCH matches nothing and reads zero
  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NCH; c++) begin
      if (chan == CHAN_FIELD_W'(c)) rd_word = chan_rdata[c];
    end
    rdata_d = rd_cyc ? rd_word : rdata_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign SRAM_RDATA = rdata_q;

`ifdef OPERAND_UNPACKER_IRQ_EN
  logic irq_q, irq_d;
  always_comb irq_d = |chan_irq;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end
  assign IRQ = irq_q;
`else
  logic unused_irq;
  assign unused_irq = |chan_irq;
  assign IRQ        = 1'b0;
`endif

endmodule

// File: tb/tb_operand_unpacker_mc.sv
// tb/tb_operand_unpacker_mc.sv - directed self-checking bench for operand_unpacker_mc
module tb_operand_unpacker_mc;

  localparam int NCH  = 2;
  localparam int OPW  = 1279;
  localparam int RESW = 1284;
  localparam int DW   = 64;
  localparam int AW   = 32;

`ifdef OPERAND_UNPACKER_IRQ_EN
  localparam logic [63:0] IRQ_ON = 64'd1;
`else
  localparam logic [63:0] IRQ_ON = 64'd0;
`endif

  logic                CLK = 1'b0;
  logic                RESET;
  logic                SRAM_CEn;
  logic [AW-1:0]       SRAM_ADDR;
  logic [DW-1:0]       SRAM_WDATA;
  logic                SRAM_WEn;
  logic [DW/8-1:0]     SRAM_WBEn;
  logic [DW-1:0]       SRAM_RDATA;
  logic [NCH-1:0]      START;
  logic [NCH-1:0]      DONE;
  logic [NCH*OPW-1:0]  ARG_A, ARG_B;
  logic [NCH*RESW-1:0] RESULT_A, RESULT_B;
  logic                IRQ;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] rd;

  always #5 CLK = ~CLK;

  operand_unpacker_mc #(.NCH(NCH), .OPW(OPW), .RESW(RESW), .DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RESET(RESET), .SRAM_CEn(SRAM_CEn), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_WDATA(SRAM_WDATA), .SRAM_WEn(SRAM_WEn), .SRAM_WBEn(SRAM_WBEn),
    .SRAM_RDATA(SRAM_RDATA), .START(START), .DONE(DONE), .ARG_A(ARG_A),
    .ARG_B(ARG_B), .RESULT_A(RESULT_A), .RESULT_B(RESULT_B), .IRQ(IRQ)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be_n);
    @(negedge CLK);
    SRAM_CEn = 1'b0; SRAM_WEn = 1'b0; SRAM_ADDR = a; SRAM_WDATA = d; SRAM_WBEn = be_n;
    @(posedge CLK); #1;
    SRAM_CEn = 1'b1; SRAM_WEn = 1'b1;
  endtask

  task automatic do_rd(input logic [31:0] a, output logic [63:0] d);
    @(negedge CLK);
    SRAM_CEn = 1'b0; SRAM_WEn = 1'b1; SRAM_ADDR = a;
    @(posedge CLK); #1;
    SRAM_CEn = 1'b1;
    d = SRAM_RDATA;
  endtask

  initial begin
    RESET = 1'b1; SRAM_CEn = 1'b1; SRAM_WEn = 1'b1; SRAM_ADDR = '0;
    SRAM_WDATA = '0; SRAM_WBEn = '1; DONE = '0; RESULT_A = '0; RESULT_B = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_start", START, 64'd0);
    check("rst_irq", IRQ, 64'd0);
    check("rst_rdata", SRAM_RDATA, 64'd0);
    check("rst_arg_a", ARG_A[63:0], 64'd0);
    RESET = 1'b0;

    // Byte-enabled operand write
    do_wr(32'h0000_0100, 64'h1122334455667788, 8'hF0);
    check("arga_wben", ARG_A[63:0], 64'h0000_0000_5566_7788);
    do_rd(32'h0000_0100, rd);
    check("arga_rd_w0", rd, 64'h0000_0000_5566_7788);

    // Top word: only 63 bits exist above bit 1215
    do_wr(32'h0000_0198, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    check("arga_top_bits", ARG_A[1278:1216], 64'h7FFF_FFFF_FFFF_FFFF);
    check("arga_no_spill", ARG_A[OPW +: 64], 64'd0);
    do_rd(32'h0000_0198, rd);
    check("arga_rd_w19", rd, 64'h7FFF_FFFF_FFFF_FFFF);

    // Out-of-range word, channel and offsets
    do_rd(32'h0000_01A0, rd);
    check("arga_w20_zero", rd, 64'd0);
    do_rd(32'h0000_3100, rd);
    check("chan3_rd_zero", rd, 64'd0);
    do_wr(32'h0000_3100, 64'hDEAD_BEEF, 8'h00);
    check("chan3_wr_ignored", ARG_A[OPW +: 64], 64'd0);
    do_rd(32'h0000_0008, rd);
    check("unmapped_008", rd, 64'd0);
    do_rd(32'h0000_0900, rd);
    check("unmapped_900", rd, 64'd0);

    // Channel 1 start / completion
    do_wr(32'h0000_1000, 64'h1, 8'h00);
    check("ch1_start_pulse", START, 64'h2);
    @(posedge CLK); #1;
    check("ch1_start_once", START, 64'h0);
    do_rd(32'h0000_1000, rd);
    check("ch1_ctrl_busy", rd, 64'h1);
    RESULT_A[RESW +: 64] = 64'd5;
    RESULT_A[RESW + 1280 +: 4] = 4'hA;
    RESULT_B[RESW +: 64] = 64'h77;
    @(negedge CLK); DONE[1] = 1'b1;
    @(posedge CLK); #1; DONE[1] = 1'b0;
    do_rd(32'h0000_1500, rd);
    check("ch1_res_a_w0", rd, 64'd5);
    do_rd(32'h0000_1000, rd);
    check("ch1_ctrl_done", rd, 64'h4);
    do_rd(32'h0000_1700, rd);
    check("ch1_res_b_w0", rd, 64'h77);
    do_rd(32'h0000_15A0, rd);
    check("ch1_res_a_w20", rd, 64'hA);
    do_rd(32'h0000_15A8, rd);
    check("ch1_res_a_w21_zero", rd, 64'd0);

    // Channel 0 run: operand writes and restarts ignored
    do_wr(32'h0000_0300, 64'h1234, 8'h00);
    do_wr(32'h0000_0000, 64'h1, 8'h00);
    check("ch0_start_pulse", START, 64'h1);
    @(posedge CLK); #1;
    do_wr(32'h0000_0300, 64'hFFFF, 8'h00);
    check("ch0_argb_locked", ARG_B[63:0], 64'h1234);
    do_wr(32'h0000_0000, 64'h1, 8'h00);
    check("ch0_no_restart", START, 64'h0);
    @(posedge CLK); #1;
    check("ch0_no_restart2", START, 64'h0);
    do_wr(32'h0000_1300, 64'hABCD, 8'h00);
    check("ch1_argb_indep", ARG_B[OPW +: 64], 64'hABCD);
    RESULT_A[63:0] = 64'h99;
    @(negedge CLK); DONE[0] = 1'b1;
    @(posedge CLK); #1; DONE[0] = 1'b0;
    do_rd(32'h0000_0000, rd);
    check("ch0_ctrl_done", rd, 64'h4);
    do_rd(32'h0000_0500, rd);
    check("ch0_res_a", rd, 64'h99);
    do_wr(32'h0000_0100, 64'h0, 8'hFF);
    check("rdata_hold", SRAM_RDATA, 64'h99);

    // Capture and W1C in the same cycle: done stays set
    do_wr(32'h0000_0000, 64'h1, 8'h00);
    @(posedge CLK); #1;
    @(negedge CLK);
    DONE[0] = 1'b1; SRAM_CEn = 1'b0; SRAM_WEn = 1'b0; SRAM_ADDR = 32'h0; SRAM_WDATA = 64'h4; SRAM_WBEn = 8'h00;
    @(posedge CLK); #1;
    SRAM_CEn = 1'b1; SRAM_WEn = 1'b1; DONE[0] = 1'b0;
    do_rd(32'h0000_0000, rd);
    check("w1c_vs_capture", rd, 64'h4);
    do_wr(32'h0000_0000, 64'h4, 8'h00);
    do_rd(32'h0000_0000, rd);
    check("w1c_clears", rd, 64'h0);

    // Interrupt on channel 1
    do_wr(32'h0000_1000, 64'h3, 8'h00);
    check("irq_start_pulse", START, 64'h2);
    @(posedge CLK); #1;
    @(negedge CLK); DONE[1] = 1'b1;
    @(posedge CLK); #1; DONE[1] = 1'b0;
    check("irq_not_yet", IRQ, 64'd0);
    @(posedge CLK); #1;
    check("irq_set", IRQ, IRQ_ON);
    do_wr(32'h0000_1000, 64'h6, 8'h00);
    check("irq_held_edge", IRQ, IRQ_ON);
    @(posedge CLK); #1;
    check("irq_cleared", IRQ, 64'd0);
    do_rd(32'h0000_1000, rd);
    check("ctrl_irq_en", rd, IRQ_ON << 1);

    // Reset during a run abandons it
    do_wr(32'h0000_0000, 64'h3, 8'h00);
    check("rr_start_pulse", START, 64'h1);
    #2 RESET = 1'b1;
    #1;
    check("rr_async_start", START, 64'h0);
    check("rr_async_rdata", SRAM_RDATA, 64'd0);
    DONE[0] = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check("rr_no_start", START, 64'h0);
      check("rr_no_irq", IRQ, 64'd0);
    end
    DONE[0] = 1'b0;
    do_rd(32'h0000_0000, rd);
    check("rr_ctrl_zero", rd, 64'd0);
    do_rd(32'h0000_0500, rd);
    check("rr_no_capture", rd, 64'd0);
    check("rr_argb_zero", ARG_B[63:0], 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
